// File: rtl/crf_pkg.sv
// Shared definitions for the upsampler config-register-file master:
// register map, AXI response codes and the sequencer state type.
package crf_pkg;

    // Config register file offsets
    localparam logic [7:0] UPSTR   = 8'h00;
    localparam logic [7:0] UPENDR  = 8'h04;
    localparam logic [7:0] UPSRCAR = 8'h08;
    localparam logic [7:0] UPDSTAR = 8'h0C;

    // UPENDR bit that flags frame completion
    localparam int unsigned UPENDR_DONE_BIT = 0;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic [2:0] {
        IDLE,
        WR_SRC,
        WR_DST,
        WR_GO,
        POLL_WAIT,
        RD_ADDR,
        RD_DATA,
        FINISH
    } state_t;

endpackage

// File: rtl/crf_lite_cfg_master_if.sv
// AXI4-Lite bundle between the config master and the register file slave.
interface crf_lite_cfg_master_if #(
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ADDR_WIDTH = 32
);

    logic                          awvalid;
    logic                          awready;
    logic [AXI_ADDR_WIDTH-1:0]     awaddr;
    logic [2:0]                    awprot;
    logic                          wvalid;
    logic                          wready;
    logic [AXI_DATA_WIDTH-1:0]     wdata;
    logic [AXI_DATA_WIDTH/8-1:0]   wstrb;
    logic                          bvalid;
    logic [1:0]                    bresp;
    logic                          bready;
    logic                          arvalid;
    logic                          arready;
    logic [AXI_ADDR_WIDTH-1:0]     araddr;
    logic [2:0]                    arprot;
    logic                          rvalid;
    logic [AXI_DATA_WIDTH-1:0]     rdata;
    logic [1:0]                    rresp;
    logic                          rready;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        output arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        input  arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

endinterface

// File: rtl/crf_lite_cfg_master_axil_single_write.sv
// Single AXI4-Lite write engine: issues AW and W together, lets each drop on
// its own handshake, then collects B and reports it as a one-cycle ack.
module axil_single_write
    import crf_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic                  wvalid,
    input  logic                  wready,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic                  bvalid,
    input  logic [1:0]            bresp,
    output logic                  bready,
    output logic                  ack,
    output axi_resp_t             resp
);

    logic aw_clear;
    logic w_clear;

    // A channel is clear when it is idle or completing this cycle
    assign aw_clear = !awvalid || awready;
    assign w_clear  = !wvalid  || wready;

    // Handshake engine: launch on req, retire AW/W independently, then B
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            awvalid <= 1'b0;
            awaddr  <= '0;
            wvalid  <= 1'b0;
            wdata   <= '0;
            bready  <= 1'b0;
            ack     <= 1'b0;
            resp    <= OKAY;
        end else begin
            ack <= 1'b0;
            if (req) begin
                awvalid <= 1'b1;
                wvalid  <= 1'b1;
                awaddr  <= addr;
                wdata   <= data;
                bready  <= 1'b0;
            end else begin
                if (awvalid && awready) awvalid <= 1'b0;
                if (wvalid && wready)   wvalid  <= 1'b0;
                // Last outstanding address/data handshake opens the B phase
                if ((awvalid || wvalid) && aw_clear && w_clear) bready <= 1'b1;
                if (bready && bvalid) begin
                    bready <= 1'b0;
                    ack    <= 1'b1;
                    resp   <= axi_resp_t'(bresp);
                end
            end
        end
    end

endmodule

// File: rtl/crf_lite_cfg_master.sv
// AXI4-Lite initiator that programs the upsampler config register file
// (source, destination, start) and polls UPENDR until the frame completes.
module crf_lite_cfg_master
    import crf_pkg::*;
#(
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned POLL_GAP       = 16,
    parameter int unsigned POLL_MAX       = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [AXI_DATA_WIDTH-1:0] src_addr,
    input  logic [AXI_DATA_WIDTH-1:0] dst_addr,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    crf_lite_cfg_master_if.master     m_axi
);

    localparam int unsigned PW = $clog2(POLL_MAX + 1);
    localparam int unsigned GW = $clog2(POLL_GAP + 1);
    localparam logic [AXI_DATA_WIDTH-1:0] DONE_MASK = AXI_DATA_WIDTH'(1) << UPENDR_DONE_BIT;

    state_t                    state;
    logic [AXI_DATA_WIDTH-1:0] dst_q;
    logic [PW-1:0]             poll_cnt;
    logic [PW-1:0]             poll_next;
    logic [GW-1:0]             gap_cnt;
    logic                      ar_valid;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic                      r_ready;
    logic                      rd_done;

    logic                      wr_req;
    logic [AXI_ADDR_WIDTH-1:0] wr_addr;
    logic [AXI_DATA_WIDTH-1:0] wr_data;
    logic                      wr_ack;
    axi_resp_t                 wr_resp;

    assign m_axi.awprot  = '0;
    assign m_axi.arprot  = '0;
    assign m_axi.wstrb   = '1;
    assign m_axi.arvalid = ar_valid;
    assign m_axi.araddr  = ar_addr;
    assign m_axi.rready  = r_ready;

    assign rd_done   = |(m_axi.rdata & DONE_MASK);
    assign poll_next = (poll_cnt == PW'(POLL_MAX)) ? poll_cnt : poll_cnt + PW'(1);

    axil_single_write #(
        .ADDR_WIDTH (AXI_ADDR_WIDTH),
        .DATA_WIDTH (AXI_DATA_WIDTH)
    ) u_wr (
        .clk     (clk),
        .rst     (rst),
        .req     (wr_req),
        .addr    (wr_addr),
        .data    (wr_data),
        .awvalid (m_axi.awvalid),
        .awready (m_axi.awready),
        .awaddr  (m_axi.awaddr),
        .wvalid  (m_axi.wvalid),
        .wready  (m_axi.wready),
        .wdata   (m_axi.wdata),
        .bvalid  (m_axi.bvalid),
        .bresp   (m_axi.bresp),
        .bready  (m_axi.bready),
        .ack     (wr_ack),
        .resp    (wr_resp)
    );

    // Launch the next write on the same edge that enters its state, so
    // AW/W valid is already up in the first cycle of WR_SRC/WR_DST/WR_GO.
    // The write engine holds the source address, so only dst needs a copy.
    always_comb begin
        wr_req  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    wr_req  = 1'b1;
                    wr_addr = AXI_ADDR_WIDTH'(UPSRCAR);
                    wr_data = src_addr;
                end
            end
            WR_SRC: begin
                if (wr_ack && wr_resp == OKAY) begin
                    wr_req  = 1'b1;
                    wr_addr = AXI_ADDR_WIDTH'(UPDSTAR);
                    wr_data = dst_q;
                end
            end
            WR_DST: begin
                if (wr_ack && wr_resp == OKAY) begin
                    wr_req  = 1'b1;
                    wr_addr = AXI_ADDR_WIDTH'(UPSTR);
                    wr_data = AXI_DATA_WIDTH'(1);
                end
            end
            default: ;
        endcase
    end

    // Sequencer: three writes, gapped UPENDR polling, one-cycle done/err
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            dst_q    <= '0;
            poll_cnt <= '0;
            gap_cnt  <= '0;
            ar_valid <= 1'b0;
            ar_addr  <= '0;
            r_ready  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    err  <= 1'b0;
                    if (start) begin
                        dst_q <= dst_addr;
                        busy  <= 1'b1;
                        state <= WR_SRC;
                    end
                end
                WR_SRC, WR_DST, WR_GO: begin
                    if (wr_ack) begin
                        if (wr_resp != OKAY) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            err   <= 1'b1;
                            state <= FINISH;
                        end else if (state == WR_SRC) begin
                            state <= WR_DST;
                        end else if (state == WR_DST) begin
                            state <= WR_GO;
                        end else begin
                            poll_cnt <= '0;
                            gap_cnt  <= '0;
                            state    <= POLL_WAIT;
                        end
                    end
                end
                POLL_WAIT: begin
                    if (gap_cnt == GW'(POLL_GAP - 1)) begin
                        gap_cnt  <= '0;
                        ar_valid <= 1'b1;
                        ar_addr  <= AXI_ADDR_WIDTH'(UPENDR);
                        state    <= RD_ADDR;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                RD_ADDR: begin
                    if (m_axi.arready) begin
                        ar_valid <= 1'b0;
                        r_ready  <= 1'b1;
                        state    <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (m_axi.rvalid) begin
                        r_ready  <= 1'b0;
                        poll_cnt <= poll_next;
                        if (axi_resp_t'(m_axi.rresp) != OKAY) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            err   <= 1'b1;
                            state <= FINISH;
                        end else if (rd_done) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            err   <= 1'b0;
                            state <= FINISH;
                        end else if (poll_next == PW'(POLL_MAX)) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            err   <= 1'b1;
                            state <= FINISH;
                        end else begin
                            gap_cnt <= '0;
                            state   <= POLL_WAIT;
                        end
                    end
                end
                FINISH: begin
                    done  <= 1'b0;
                    err   <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crf_lite_cfg_master.sv
// Directed bench for crf_lite_cfg_master with a small AXI-Lite slave model.
module tb_crf_lite_cfg_master;
    import crf_pkg::*;

    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 32;
    localparam int unsigned GAP  = 3;
    localparam int unsigned PMAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] src_addr;
    logic [DW-1:0] dst_addr;
    logic          busy;
    logic          done;
    logic          err;

    crf_lite_cfg_master_if #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)) m_axi_if ();

    crf_lite_cfg_master #(
        .AXI_DATA_WIDTH (DW),
        .AXI_ADDR_WIDTH (AW),
        .POLL_GAP       (GAP),
        .POLL_MAX       (PMAX)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .m_axi    (m_axi_if)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Slave configuration
    int aw_delay   = 0;
    int w_delay    = 0;
    int err_idx    = -1;
    int done_after = 0;

    // Slave / monitor state
    bit          aw_got, w_got, ar_got;
    int          aw_cnt, w_cnt;
    logic [31:0] aw_log, w_log;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    longint      b_cycle[$];
    longint      ar_cycle[$];
    longint      cycle = 0;
    int          rd_count, done_cnt, viol;
    logic        done_err;
    logic        prev_awv, prev_awr, prev_wv, prev_wr;
    logic [31:0] prev_awaddr, prev_wdata;

    // Edge monitor: handshakes, logs and protocol rules
    always @(posedge clk) begin
        cycle++;
        if (rst) begin
            aw_got = 0; w_got = 0; ar_got = 0;
            prev_awv = 0; prev_wv = 0; prev_awr = 0; prev_wr = 0;
        end else begin
            if (m_axi_if.bready && !(aw_got && w_got)) viol++;
            if (prev_awv && !prev_awr && (!m_axi_if.awvalid || m_axi_if.awaddr != prev_awaddr)) viol++;
            if (prev_wv && !prev_wr && (!m_axi_if.wvalid || m_axi_if.wdata != prev_wdata)) viol++;
            if ((m_axi_if.awvalid || m_axi_if.wvalid || m_axi_if.bready) &&
                (m_axi_if.arvalid || m_axi_if.rready)) viol++;
            if (m_axi_if.awvalid && m_axi_if.awready) begin aw_got = 1; aw_log = m_axi_if.awaddr; end
            if (m_axi_if.wvalid && m_axi_if.wready) begin w_got = 1; w_log = m_axi_if.wdata; end
            if (m_axi_if.bvalid && m_axi_if.bready) begin
                wr_addr_q.push_back(aw_log);
                wr_data_q.push_back(w_log);
                b_cycle.push_back(cycle);
                aw_got = 0; w_got = 0;
            end
            if (m_axi_if.arvalid && m_axi_if.arready) begin
                ar_got = 1;
                rd_count++;
                ar_cycle.push_back(cycle);
                if (m_axi_if.araddr != 32'h4) viol++;
            end
            if (m_axi_if.rvalid && m_axi_if.rready) ar_got = 0;
            if (done) begin done_cnt++; done_err = err; end
            prev_awv = m_axi_if.awvalid; prev_awr = m_axi_if.awready; prev_awaddr = m_axi_if.awaddr;
            prev_wv  = m_axi_if.wvalid;  prev_wr  = m_axi_if.wready;  prev_wdata  = m_axi_if.wdata;
        end
    end

    // Slave drive on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            m_axi_if.awready = 0; m_axi_if.wready = 0; m_axi_if.bvalid = 0;
            m_axi_if.arready = 0; m_axi_if.rvalid = 0;
            aw_cnt = 0; w_cnt = 0;
        end else begin
            if (m_axi_if.awvalid && !aw_got) begin
                if (aw_cnt >= aw_delay) m_axi_if.awready = 1;
                else begin m_axi_if.awready = 0; aw_cnt++; end
            end else begin m_axi_if.awready = 0; aw_cnt = 0; end
            if (m_axi_if.wvalid && !w_got) begin
                if (w_cnt >= w_delay) m_axi_if.wready = 1;
                else begin m_axi_if.wready = 0; w_cnt++; end
            end else begin m_axi_if.wready = 0; w_cnt = 0; end
            m_axi_if.bvalid  = aw_got && w_got;
            m_axi_if.bresp   = (wr_addr_q.size() == err_idx) ? 2'b10 : 2'b00;
            m_axi_if.arready = m_axi_if.arvalid && !ar_got;
            m_axi_if.rvalid  = ar_got;
            m_axi_if.rresp   = 2'b00;
            m_axi_if.rdata   = (rd_count - 1 == done_after) ? 32'h8000_0001 : 32'hFFFF_FFFE;
        end
    end

    function automatic logic [31:0] wa(input int i);
        return (i < wr_addr_q.size()) ? wr_addr_q[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] wd(input int i);
        return (i < wr_data_q.size()) ? wr_data_q[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic int min_ar_gap();
        int m = 1000000;
        for (int i = 1; i < ar_cycle.size(); i++)
            if (int'(ar_cycle[i] - ar_cycle[i-1]) < m) m = int'(ar_cycle[i] - ar_cycle[i-1]);
        return m;
    endfunction

    task automatic clear_logs();
        wr_addr_q.delete(); wr_data_q.delete(); b_cycle.delete(); ar_cycle.delete();
        rd_count = 0; done_cnt = 0; done_err = 0; viol = 0;
    endtask

    task automatic wait_done(input string tag);
        bit ok = 0;
        for (int i = 0; i < 3000; i++) begin
            if (done_cnt > 0) begin ok = 1; break; end
            @(negedge clk);
        end
        check({tag, "_done_seen"}, 32'(ok), 32'd1);
    endtask

    task automatic run_job(input string tag, input logic [31:0] s, input logic [31:0] d);
        clear_logs();
        @(negedge clk);
        src_addr = s; dst_addr = d; start = 1;
        @(negedge clk);
        start = 0;
        check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        wait_done(tag);
        repeat (4) @(negedge clk);
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic check_full_writes(input string tag, input logic [31:0] s, input logic [31:0] d);
        check({tag, "_nwr"},   32'(wr_addr_q.size()), 32'd3);
        check({tag, "_wa0"},   wa(0), 32'h08);
        check({tag, "_wd0"},   wd(0), s);
        check({tag, "_wa1"},   wa(1), 32'h0C);
        check({tag, "_wd1"},   wd(1), d);
        check({tag, "_wa2"},   wa(2), 32'h00);
        check({tag, "_wd2"},   wd(2), 32'h1);
        check({tag, "_viol"},  32'(viol), 32'd0);
        check({tag, "_ndone"}, 32'(done_cnt), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_axi_if.awready = 0; m_axi_if.wready = 0; m_axi_if.bvalid = 0; m_axi_if.bresp = 0;
        m_axi_if.arready = 0; m_axi_if.rvalid = 0; m_axi_if.rdata = 0; m_axi_if.rresp = 0;
        rst = 1; start = 0; src_addr = 0; dst_addr = 0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy",    32'(busy), 32'd0);
        check("rst_done",    32'(done), 32'd0);
        check("rst_err",     32'(err), 32'd0);
        check("rst_valids",  32'({m_axi_if.awvalid, m_axi_if.wvalid, m_axi_if.bready,
                                  m_axi_if.arvalid, m_axi_if.rready}), 32'd0);
        check("rst_awaddr",  m_axi_if.awaddr, 32'd0);
        check("rst_wdata",   m_axi_if.wdata, 32'd0);
        check("rst_araddr",  m_axi_if.araddr, 32'd0);
        rst = 0;
        @(negedge clk);
        check("wstrb",       32'(m_axi_if.wstrb), 32'hF);
        check("prot",        32'({m_axi_if.awprot, m_axi_if.arprot}), 32'd0);

        // Normal completion: UPENDR reads 0,0,1
        done_after = 2;
        run_job("norm", 32'h1000_0000, 32'h2000_0000);
        check_full_writes("norm", 32'h1000_0000, 32'h2000_0000);
        check("norm_nrd",  32'(rd_count), 32'd3);
        check("norm_err",  32'(done_err), 32'd0);
        check("norm_b01",  32'(b_cycle.size() == 3 ? b_cycle[1] - b_cycle[0] : 0), 32'd3);
        check("norm_b12",  32'(b_cycle.size() == 3 ? b_cycle[2] - b_cycle[1] : 0), 32'd3);
        check("norm_argap", 32'(min_ar_gap() >= int'(GAP)), 32'd1);

        // AW delayed, W immediate; then the reverse
        done_after = 0; aw_delay = 5; w_delay = 0;
        run_job("awslow", 32'h1111_2220, 32'h3333_4440);
        check_full_writes("awslow", 32'h1111_2220, 32'h3333_4440);
        check("awslow_err", 32'(done_err), 32'd0);
        aw_delay = 0; w_delay = 5;
        run_job("wslow", 32'h0ABC_DEF0, 32'h0FED_CBA0);
        check_full_writes("wslow", 32'h0ABC_DEF0, 32'h0FED_CBA0);
        check("wslow_err", 32'(done_err), 32'd0);
        w_delay = 0;

        // SLVERR on the UPDSTAR write: no UPSTR write, no reads
        err_idx = 1;
        run_job("werr", 32'h5000_0000, 32'h6000_0000);
        check("werr_nwr",   32'(wr_addr_q.size()), 32'd2);
        check("werr_wa1",   wa(1), 32'h0C);
        check("werr_nrd",   32'(rd_count), 32'd0);
        check("werr_ndone", 32'(done_cnt), 32'd1);
        check("werr_err",   32'(done_err), 32'd1);
        check("werr_idle",  32'({m_axi_if.awvalid, m_axi_if.wvalid, m_axi_if.arvalid}), 32'd0);
        err_idx = -1;

        // Timeout: UPENDR never completes
        done_after = 1000;
        run_job("tmo", 32'h7000_0000, 32'h7100_0000);
        check("tmo_nrd",   32'(rd_count), 32'(PMAX));
        check("tmo_err",   32'(done_err), 32'd1);
        check("tmo_ndone", 32'(done_cnt), 32'd1);
        check("tmo_argap", 32'(min_ar_gap() >= int'(GAP)), 32'd1);
        check("tmo_viol",  32'(viol), 32'd0);

        // Asynchronous reset while awvalid is held
        done_after = 2; aw_delay = 8;
        clear_logs();
        @(negedge clk);
        src_addr = 32'h9000_0000; dst_addr = 32'h9100_0000; start = 1;
        @(negedge clk);
        start = 0;
        repeat (2) @(negedge clk);
        check("rstw_awvalid_pre", 32'(m_axi_if.awvalid), 32'd1);
        #2 rst = 1;
        #1;
        check("rstw_valids", 32'({m_axi_if.awvalid, m_axi_if.wvalid, m_axi_if.bready, busy, done}), 32'd0);
        check("rstw_awaddr", m_axi_if.awaddr, 32'd0);
        check("rstw_wdata",  m_axi_if.wdata, 32'd0);
        repeat (2) @(negedge clk);
        rst = 0; aw_delay = 0;
        run_job("after_rst", 32'h3000_0000, 32'h4000_0000);
        check_full_writes("after_rst", 32'h3000_0000, 32'h4000_0000);
        check("after_rst_err", 32'(done_err), 32'd0);

        // Start pulsed during RD_DATA is ignored
        done_after = 2;
        clear_logs();
        @(negedge clk);
        src_addr = 32'hA000_0000; dst_addr = 32'hB000_0000; start = 1;
        @(negedge clk);
        start = 0;
        begin
            bit seen = 0;
            for (int i = 0; i < 500; i++) begin
                if (m_axi_if.rready) begin seen = 1; break; end
                @(negedge clk);
            end
            check("sbusy_rd_seen", 32'(seen), 32'd1);
        end
        start = 1;
        @(negedge clk);
        start = 0;
        wait_done("sbusy");
        repeat (40) @(negedge clk);
        check_full_writes("sbusy", 32'hA000_0000, 32'hB000_0000);
        check("sbusy_nrd", 32'(rd_count), 32'd3);
        check("sbusy_err", 32'(done_err), 32'd0);
        check("sbusy_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
